// File: rtl/perceptron_bpred_core.sv
// Perceptron branch-direction predictor: one-cycle fetch lookup, speculative global history,
// two-cycle execute training, self-clearing table. Optional debug read port: PERCEPTRON_DEBUG_EN.
module perceptron_bpred_core #(
  parameter int PC_W        = 32,
  parameter int HIST_LEN    = 16,
  parameter int TABLE_DEPTH = 64,
  parameter int WEIGHT_W    = 8,
  parameter int THETA       = 44,
  localparam int IDX_W      = $clog2(TABLE_DEPTH),
  localparam int WSEL_W     = $clog2(HIST_LEN + 1),
  localparam int SUM_W      = WEIGHT_W + WSEL_W + 1,
  localparam int META_W     = HIST_LEN + SUM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_bpredictor_req,
  input  logic [PC_W-1:0]   fetch_bpredictor_PC,
  input  logic              soin_bpredictor_stall,
  output logic              bpredictor_fetch_valid,
  output logic              bpredictor_fetch_p_dir,
  output logic [META_W-1:0] bpredictor_fetch_meta,
  output logic              bpredictor_ready,
  input  logic              execute_bpredictor_update,
  input  logic [PC_W-1:0]   execute_bpredictor_PC4,
  input  logic              execute_bpredictor_dir,
  input  logic              execute_bpredictor_miss,
  input  logic [META_W-1:0] execute_bpredictor_meta,
  output logic              bpredictor_execute_busy
`ifdef PERCEPTRON_DEBUG_EN
  ,
  input  logic [IDX_W+WSEL_W-1:0] soin_bpredictor_debug_sel,
  output logic [WEIGHT_W-1:0]     bpredictor_debug_data
`endif
);

  localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
  localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     init_cnt_q, init_cnt_d;
  logic [HIST_LEN-1:0]  hist_q;
  logic                 valid_q, p_dir_q;
  logic [META_W-1:0]    meta_q;
  logic [IDX_W-1:0]     upd_idx_q;
  logic                 upd_dir_q, upd_train_q;
  logic [HIST_LEN-1:0]  upd_hist_q;
  logic [ROW_W-1:0]     rd_row_q;
  logic [ROW_W-1:0]     table_q [TABLE_DEPTH];

  logic                 fetch_acc, upd_acc, wr_en;
  logic [IDX_W-1:0]     fetch_idx, ex_idx;
  logic [PC_W-1:0]      ex_pc;
  logic [ROW_W-1:0]     row_rd, new_row;
  logic signed [SUM_W-1:0] sum_c, ex_sum;
  logic [SUM_W-1:0]     ex_abs;
  logic                 p_dir_c, ex_train;
  logic [HIST_LEN-1:0]  ex_hist;

  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic up);
    if (up) return (w == W_MAX) ? w : w + 1'b1;
    else    return (w == W_MIN) ? w : w - 1'b1;
  endfunction

  assign fetch_acc = fetch_bpredictor_req && (state_q != ST_INIT) && !soin_bpredictor_stall;
  assign upd_acc   = execute_bpredictor_update && (state_q == ST_IDLE);
  assign wr_en     = (state_q == ST_WR) && upd_train_q;
  assign fetch_idx = fetch_bpredictor_PC[IDX_W+1:2];
  assign ex_pc     = execute_bpredictor_PC4 - PC_W'(4);
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_hist   = execute_bpredictor_meta[META_W-1:SUM_W];
  assign ex_sum    = execute_bpredictor_meta[SUM_W-1:0];
  // Unsigned magnitude: the most negative sum maps to 2^(SUM_W-1), still far above THETA.
  assign ex_abs    = ex_sum[SUM_W-1] ? SUM_W'(-ex_sum) : ex_sum;
  assign ex_train  = execute_bpredictor_miss || (ex_abs <= SUM_W'(THETA));

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_bpredictor_PC[PC_W-1:IDX_W+2], fetch_bpredictor_PC[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0], ex_hist[HIST_LEN-1]};

  always_comb begin
    new_row = rd_row_q;
    new_row[0 +: WEIGHT_W] = sat_step(rd_row_q[0 +: WEIGHT_W], upd_dir_q);
    for (int i = 1; i <= HIST_LEN; i++) begin
      new_row[i*WEIGHT_W +: WEIGHT_W] =
        sat_step(rd_row_q[i*WEIGHT_W +: WEIGHT_W], upd_dir_q == upd_hist_q[i-1]);
    end
  end

  // Write-first bypass so a lookup colliding with the training write sees the new weights.
  assign row_rd = (wr_en && (upd_idx_q == fetch_idx)) ? new_row : table_q[fetch_idx];

  always_comb begin
    sum_c = SUM_W'($signed(row_rd[0 +: WEIGHT_W]));
    for (int i = 1; i <= HIST_LEN; i++) begin
      if (hist_q[i-1]) sum_c = sum_c + SUM_W'($signed(row_rd[i*WEIGHT_W +: WEIGHT_W]));
      else             sum_c = sum_c - SUM_W'($signed(row_rd[i*WEIGHT_W +: WEIGHT_W]));
    end
  end
  assign p_dir_c = ~sum_c[SUM_W-1];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(TABLE_DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: if (execute_bpredictor_update) state_d = ST_RD;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      hist_q      <= '0;
      valid_q     <= 1'b0;
      p_dir_q     <= 1'b0;
      meta_q      <= '0;
      upd_idx_q   <= '0;
      upd_dir_q   <= 1'b0;
      upd_train_q <= 1'b0;
      upd_hist_q  <= '0;
      rd_row_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      if (!soin_bpredictor_stall) begin
        valid_q <= fetch_acc;
        if (fetch_acc) begin
          p_dir_q <= p_dir_c;
          meta_q  <= {hist_q, sum_c};
        end
      end
      // Misprediction repair wins over the speculative shift of a same-cycle lookup.
      if (upd_acc && execute_bpredictor_miss)
        hist_q <= {ex_hist[HIST_LEN-2:0], execute_bpredictor_dir};
      else if (fetch_acc)
        hist_q <= {hist_q[HIST_LEN-2:0], p_dir_c};
      if (upd_acc) begin
        upd_idx_q   <= ex_idx;
        upd_dir_q   <= execute_bpredictor_dir;
        upd_train_q <= ex_train;
        upd_hist_q  <= ex_hist;
      end
      if (state_q == ST_RD) rd_row_q <= table_q[upd_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)  table_q[init_cnt_q] <= '0;
    else if (wr_en)          table_q[upd_idx_q]  <= new_row;
  end

  assign bpredictor_fetch_valid  = valid_q;
  assign bpredictor_fetch_p_dir  = p_dir_q;
  assign bpredictor_fetch_meta   = meta_q;
  assign bpredictor_ready        = (state_q != ST_INIT);
  assign bpredictor_execute_busy = (state_q != ST_IDLE);

`ifdef PERCEPTRON_DEBUG_EN
  logic [WEIGHT_W-1:0] dbg_q, dbg_c;
  logic [ROW_W-1:0]    dbg_row;
  logic [WSEL_W-1:0]   dbg_wsel;

  assign dbg_row  = table_q[soin_bpredictor_debug_sel[WSEL_W +: IDX_W]];
  assign dbg_wsel = soin_bpredictor_debug_sel[WSEL_W-1:0];

  always_comb begin
    dbg_c = '0;
    for (int i = 0; i <= HIST_LEN; i++) begin
      if (dbg_wsel == WSEL_W'(i)) dbg_c = dbg_row[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dbg_q <= '0;
    else        dbg_q <= dbg_c;
  end
  assign bpredictor_debug_data = dbg_q;
`endif

endmodule

// File: tb/tb_perceptron_bpred_core.sv
// Directed scoreboard bench for perceptron_bpred_core: lookups push expected {p_dir, meta},
// a negedge monitor pops and compares whenever a fresh prediction is presented.
module tb_perceptron_bpred_core;
  localparam int PC_W = 32, HIST_LEN = 16, IDX_W = 6, WSEL_W = 5, WEIGHT_W = 8;
  localparam int SUM_W = 14, META_W = 30, EXP_W = META_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              fetch_bpredictor_req;
  logic [PC_W-1:0]   fetch_bpredictor_PC;
  logic              soin_bpredictor_stall;
  logic              bpredictor_fetch_valid;
  logic              bpredictor_fetch_p_dir;
  logic [META_W-1:0] bpredictor_fetch_meta;
  logic              bpredictor_ready;
  logic              execute_bpredictor_update;
  logic [PC_W-1:0]   execute_bpredictor_PC4;
  logic              execute_bpredictor_dir;
  logic              execute_bpredictor_miss;
  logic [META_W-1:0] execute_bpredictor_meta;
  logic              bpredictor_execute_busy;
`ifdef PERCEPTRON_DEBUG_EN
  logic [IDX_W+WSEL_W-1:0] soin_bpredictor_debug_sel;
  logic [WEIGHT_W-1:0]     bpredictor_debug_data;
`endif

  perceptron_bpred_core dut (
    .clk                       (clk),
    .reset                     (reset),
    .fetch_bpredictor_req      (fetch_bpredictor_req),
    .fetch_bpredictor_PC       (fetch_bpredictor_PC),
    .soin_bpredictor_stall     (soin_bpredictor_stall),
    .bpredictor_fetch_valid    (bpredictor_fetch_valid),
    .bpredictor_fetch_p_dir    (bpredictor_fetch_p_dir),
    .bpredictor_fetch_meta     (bpredictor_fetch_meta),
    .bpredictor_ready          (bpredictor_ready),
    .execute_bpredictor_update (execute_bpredictor_update),
    .execute_bpredictor_PC4    (execute_bpredictor_PC4),
    .execute_bpredictor_dir    (execute_bpredictor_dir),
    .execute_bpredictor_miss   (execute_bpredictor_miss),
    .execute_bpredictor_meta   (execute_bpredictor_meta),
    .bpredictor_execute_busy   (bpredictor_execute_busy)
`ifdef PERCEPTRON_DEBUG_EN
    ,
    .soin_bpredictor_debug_sel (soin_bpredictor_debug_sel),
    .bpredictor_debug_data     (bpredictor_debug_data)
`endif
  );

  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic stall_seen;

  always @(posedge clk) stall_seen <= soin_bpredictor_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk(input logic d, input logic [HIST_LEN-1:0] h, input int s);
    logic [SUM_W-1:0] sv;
    sv = SUM_W'(s);
    return {d, h, sv};
  endfunction

  // Monitor: a held output during stall is not a new prediction.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bpredictor_fetch_valid === 1'b1 && stall_seen === 1'b0) begin
        if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("lookup", {bpredictor_fetch_p_dir, bpredictor_fetch_meta}, e);
        end
      end
    end
  end

  task automatic do_lookup(input logic [PC_W-1:0] pc, input logic d, input logic [HIST_LEN-1:0] h,
                           input int s);
    fetch_bpredictor_req = 1'b1;
    fetch_bpredictor_PC  = pc;
    exp_q.push_back(mk(d, h, s));
    @(posedge clk); #1;
    fetch_bpredictor_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bpredictor_execute_busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bpredictor_execute_busy !== 1'b0) check("busy_timeout", 64'(bpredictor_execute_busy), 64'd0);
  endtask

  task automatic drive_update(input logic [PC_W-1:0] pc4, input logic d, input logic m,
                              input logic [HIST_LEN-1:0] h, input int s);
    logic [SUM_W-1:0] sv;
    sv = SUM_W'(s);
    execute_bpredictor_update = 1'b1;
    execute_bpredictor_PC4    = pc4;
    execute_bpredictor_dir    = d;
    execute_bpredictor_miss   = m;
    execute_bpredictor_meta   = {h, sv};
  endtask

  task automatic do_update(input logic [PC_W-1:0] pc4, input logic d, input logic m,
                           input logic [HIST_LEN-1:0] h, input int s);
    wait_idle();
    drive_update(pc4, d, m, h, s);
    @(posedge clk); #1;
    execute_bpredictor_update = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bpredictor_ready === 1'b1) break;
    end
    check(name, 64'(n), 64'd64);
    check({name, "_busy"}, 64'(bpredictor_execute_busy), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_valid", 64'(bpredictor_fetch_valid), 64'd0);
    check("rst_p_dir", 64'(bpredictor_fetch_p_dir), 64'd0);
    check("rst_meta",  64'(bpredictor_fetch_meta),  64'd0);
    check("rst_ready", 64'(bpredictor_ready),       64'd0);
    check("rst_busy",  64'(bpredictor_execute_busy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EXP_W-1:0] held;
    reset = 1'b0;
    fetch_bpredictor_req = 1'b0;
    fetch_bpredictor_PC = '0;
    soin_bpredictor_stall = 1'b0;
    execute_bpredictor_update = 1'b0;
    execute_bpredictor_PC4 = '0;
    execute_bpredictor_dir = 1'b0;
    execute_bpredictor_miss = 1'b0;
    execute_bpredictor_meta = '0;
`ifdef PERCEPTRON_DEBUG_EN
    soin_bpredictor_debug_sel = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;
    wait_ready("ready_latency");

    // Cleared table: sum 0 predicts taken.
    do_lookup(32'h80, 1'b1, 16'h0000, 0);

    // First training on row 32; busy spans RD and WR.
    wait_idle();
    drive_update(32'h84, 1'b0, 1'b1, 16'h0000, 0);
    @(posedge clk); #1;
    execute_bpredictor_update = 1'b0;
    check("busy_rd", 64'(bpredictor_execute_busy), 64'd1);
    @(posedge clk); #1;
    check("busy_wr", 64'(bpredictor_execute_busy), 64'd1);
    @(posedge clk); #1;
    check("busy_done", 64'(bpredictor_execute_busy), 64'd0);
    do_lookup(32'h80, 1'b0, 16'h0000, -17);

    // Saturation: drive every weight of row 32 to +127.
    for (int i = 0; i < 200; i++) do_update(32'h84, 1'b1, 1'b0, 16'hFFFF, 0);
    do_update(32'h84, 1'b1, 1'b1, 16'hFFFF, 0);
    wait_idle();
    do_lookup(32'h80, 1'b1, 16'hFFFF, 2159);
`ifdef PERCEPTRON_DEBUG_EN
    soin_bpredictor_debug_sel = {6'd32, 5'd5};
    @(posedge clk); #1;
    check("debug_sat", 64'(bpredictor_debug_data), 64'h7F);
`endif

    // Threshold boundaries on row 33.
    do_update(32'h88, 1'b1, 1'b0, 16'h0000, 45);
    wait_idle();
    do_lookup(32'h84, 1'b1, 16'hFFFF, 0);
    do_update(32'h88, 1'b1, 1'b0, 16'h0000, 44);
    wait_idle();
    do_lookup(32'h84, 1'b0, 16'hFFFF, -15);
    do_update(32'h88, 1'b1, 1'b0, 16'h0000, -44);
    wait_idle();
    do_lookup(32'h84, 1'b0, 16'hFFFE, -26);

    // Bypass on row 34; an update offered during RD must be dropped.
    do_update(32'h8C, 1'b1, 1'b0, 16'h0000, 0);
    drive_update(32'h90, 1'b0, 1'b1, 16'h1234, 0);
    @(posedge clk); #1;
    execute_bpredictor_update = 1'b0;
    do_lookup(32'h88, 1'b0, 16'hFFFC, -11);
    wait_idle();
    do_lookup(32'h8C, 1'b1, 16'hFFF8, 0);

    // Stall holds outputs and history.
    held = mk(1'b1, 16'hFFF1, 1397);
    do_lookup(32'h80, 1'b1, 16'hFFF1, 1397);
    soin_bpredictor_stall = 1'b1;
    fetch_bpredictor_req = 1'b1;
    fetch_bpredictor_PC = 32'h84;
    repeat (2) @(posedge clk);
    #1;
    check("stall_valid", 64'(bpredictor_fetch_valid), 64'd1);
    check("stall_out", {bpredictor_fetch_p_dir, bpredictor_fetch_meta}, held);
    soin_bpredictor_stall = 1'b0;
    fetch_bpredictor_req = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 64'(bpredictor_fetch_valid), 64'd0);
    do_lookup(32'h84, 1'b0, 16'hFFE3, -18);

    // Miss repair overrides the shift of a same-cycle lookup.
    wait_idle();
    drive_update(32'hA4, 1'b0, 1'b1, 16'h00F0, 0);
    do_lookup(32'h8C, 1'b1, 16'hFFC6, 0);
    execute_bpredictor_update = 1'b0;
    do_lookup(32'h8C, 1'b1, 16'h01E0, 0);
    drain();

    // Reset during RD drops the training and re-clears the table.
    wait_idle();
    do_update(32'h84, 1'b0, 1'b0, 16'h0000, 0);
    reset = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ready("ready_latency2");
    do_lookup(32'h80, 1'b1, 16'h0000, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
